// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the elastic pipeline control stage.
package pipe_ctrl_pkg;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    localparam int CTRL_OP_W = 5;
    localparam int CTRL_F3_W = 3;
    localparam int CTRL_RD_W = 5;

    localparam logic [CTRL_OP_W-1:0] NOP_OP = '0;

    typedef struct packed {
        logic [CTRL_OP_W-1:0] op;
        logic [CTRL_F3_W-1:0] f3;
        logic [CTRL_RD_W-1:0] rd;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_TWO   = OCC_TWO
    } occ_t;

endpackage

// File: rtl/pipe_ctrl_stage_if.sv
// Valid/ready control-field bus between two pipeline stages.
interface pipe_ctrl_stage_if #(
    parameter int OP_W = 5,
    parameter int F3_W = 3,
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] in_op;
    logic [F3_W-1:0] in_f3;
    logic [RD_W-1:0] in_rd;
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] out_op;
    logic [F3_W-1:0] out_f3;
    logic [RD_W-1:0] out_rd;

    modport master (
        output in_valid, in_op, in_f3, in_rd, out_ready,
        input  in_ready, out_valid, out_op, out_f3, out_rd
    );

    modport slave (
        input  in_valid, in_op, in_f3, in_rd, out_ready,
        output in_ready, out_valid, out_op, out_f3, out_rd
    );
endinterface

// File: rtl/pipe_ctrl_entry.sv
// One control-field holding register; cleared contents read as an all-zero bubble.
module pipe_ctrl_entry #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/pipe_ctrl_stage.sv
// Elastic op/funct3/rd register for one pipeline stage with optional skid entry,
// flush, hazard taps and a saturating stall counter.
//   state    | meaning
//   ST_EMPTY | nothing held, output is a bubble
//   ST_ONE   | main entry valid
//   ST_TWO   | main and skid valid, upstream blocked (SKID=1 only)
module pipe_ctrl_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int OP_W  = 5,
    parameter int F3_W  = 3,
    parameter int RD_W  = 5,
    parameter int SKID  = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    pipe_ctrl_stage_if.slave bus,
    output logic [RD_W-1:0]  hz_rd_main,
    output logic [RD_W-1:0]  hz_rd_skid,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int W = OP_W + F3_W + RD_W;

    occ_t           state, state_nxt;
    logic           push, pop;
    logic           main_load, main_clr, skid_load, skid_clr;
    logic [W-1:0]   in_word, main_d, main_q, skid_q;
    logic           main_valid;

    assign in_word = {bus.in_op, bus.in_f3, bus.in_rd};
    assign push    = bus.in_valid & bus.in_ready;
    assign pop     = main_valid & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_d    = in_word;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_load = 1'b1;
                end else if (push && SKID != 0) begin
                    state_nxt = ST_TWO;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_nxt = ST_ONE;
                    main_load = 1'b1;
                    main_d    = skid_q;
                    skid_clr  = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush discards everything, including a push offered this cycle.
        if (flush) begin
            state_nxt = ST_EMPTY;
            main_load = 1'b0;
            skid_load = 1'b0;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end
    end

    pipe_ctrl_entry #(.W(W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q),
        .valid (main_valid)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic skid_valid;
            logic in_ready_r;
            logic unused_skid_valid;

            pipe_ctrl_entry #(.W(W)) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clr),
                .d     (in_word),
                .q     (skid_q),
                .valid (skid_valid)
            );
            assign unused_skid_valid = skid_valid;

            always_ff @(posedge clk) begin
                if (!rst) in_ready_r <= 1'b1;
                else      in_ready_r <= (state_nxt != ST_TWO);
            end
            assign bus.in_ready = in_ready_r;
        end else begin : g_noskid
            logic unused_skid_ctrl;
            assign unused_skid_ctrl = skid_load | skid_clr;
            assign skid_q           = '0;
            assign bus.in_ready     = !main_valid | bus.out_ready;
        end
    endgenerate

    assign bus.out_valid = main_valid;
    assign bus.out_op    = main_q[W-1 -: OP_W];
    assign bus.out_f3    = main_q[RD_W +: F3_W];
    assign bus.out_rd    = main_q[RD_W-1:0];
    assign hz_rd_main    = main_q[RD_W-1:0];
    assign hz_rd_skid    = skid_q[RD_W-1:0];
    assign occ           = state;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= '0;
        else if (main_valid && !bus.out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed bench: skid instance (3-bit stall counter) and a no-skid instance.
module tb_pipe_ctrl_stage;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush_s = 1'b0;
    logic flush_n = 1'b0;
    logic [4:0] hzm_s, hzk_s, hzm_n, hzk_n;
    logic [1:0] occ_s, occ_n;
    logic [2:0] stall_s;
    logic [15:0] stall_n;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl_stage_if #(.OP_W(5), .F3_W(3), .RD_W(5)) bs ();
    pipe_ctrl_stage_if #(.OP_W(5), .F3_W(3), .RD_W(5)) bn ();

    pipe_ctrl_stage #(.SKID(1), .CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .flush(flush_s), .bus(bs),
        .hz_rd_main(hzm_s), .hz_rd_skid(hzk_s), .occ(occ_s), .stall_cnt(stall_s)
    );

    pipe_ctrl_stage #(.SKID(0), .CNT_W(16)) dut_n (
        .clk(clk), .rst(rst), .flush(flush_n), .bus(bn),
        .hz_rd_main(hzm_n), .hz_rd_skid(hzk_n), .occ(occ_n), .stall_cnt(stall_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic v, input ctrl_t c);
        bs.in_valid = v;
        bs.in_op    = c.op;
        bs.in_f3    = c.f3;
        bs.in_rd    = c.rd;
    endtask

    task automatic drive_n(input logic v, input ctrl_t c);
        bn.in_valid = v;
        bn.in_op    = c.op;
        bn.in_f3    = c.f3;
        bn.in_rd    = c.rd;
    endtask

    initial begin
        ctrl_t idle;
        idle = '{op: NOP_OP, f3: 3'd0, rd: 5'd0};
        drive_s(1'b1, '{op: 5'h1f, f3: 3'd7, rd: 5'd31});
        drive_n(1'b0, idle);
        bs.out_ready = 1'b0;
        bn.out_ready = 1'b0;

        // reset with in_valid held high
        repeat (3) tick();
        chk("rst_out_valid", bs.out_valid, 0);
        chk("rst_out_op", bs.out_op, 0);
        chk("rst_out_rd", bs.out_rd, 0);
        chk("rst_occ", occ_s, 0);
        chk("rst_stall", stall_s, 0);
        rst = 1'b1;
        drive_s(1'b0, idle);
        tick();
        chk("rst_in_ready", bs.in_ready, 1);
        chk("rst_idle_valid", bs.out_valid, 0);

        // streaming
        bs.out_ready = 1'b1;
        drive_s(1'b1, '{op: 5'h13, f3: 3'd0, rd: 5'd5});
        tick();
        chk("str1_valid", bs.out_valid, 1);
        chk("str1_op", bs.out_op, 5'h13);
        chk("str1_rd", bs.out_rd, 5);
        chk("str1_occ", occ_s, 1);
        drive_s(1'b1, '{op: 5'h03, f3: 3'd2, rd: 5'd7});
        tick();
        chk("str2_op", bs.out_op, 5'h03);
        chk("str2_f3", bs.out_f3, 2);
        chk("str2_rd", bs.out_rd, 7);
        chk("str2_occ", occ_s, 1);
        drive_s(1'b0, idle);
        tick();
        chk("str_drain_occ", occ_s, 0);
        chk("str_drain_valid", bs.out_valid, 0);
        chk("str_bubble_op", bs.out_op, 0);
        chk("str_bubble_rd", bs.out_rd, 0);

        // backpressure into skid
        bs.out_ready = 1'b0;
        drive_s(1'b1, '{op: 5'h13, f3: 3'd0, rd: 5'd5});
        tick();
        chk("bp1_occ", occ_s, 1);
        drive_s(1'b1, '{op: 5'h0c, f3: 3'd1, rd: 5'd7});
        tick();
        chk("bp2_occ", occ_s, 2);
        chk("bp2_in_ready", bs.in_ready, 0);
        chk("bp2_hz_main", hzm_s, 5);
        chk("bp2_hz_skid", hzk_s, 7);
        chk("bp2_stall", stall_s, 1);
        drive_s(1'b0, idle);
        bs.out_ready = 1'b1;
        chk("bp_pop1_rd", bs.out_rd, 5);
        tick();
        chk("bp_pop2_rd", bs.out_rd, 7);
        chk("bp_pop2_op", bs.out_op, 5'h0c);
        chk("bp_pop2_f3", bs.out_f3, 1);
        chk("bp_pop2_occ", occ_s, 1);
        chk("bp_pop2_hz_skid", hzk_s, 0);
        chk("bp_pop2_in_ready", bs.in_ready, 1);
        tick();
        chk("bp_done_occ", occ_s, 0);
        chk("bp_done_valid", bs.out_valid, 0);
        chk("bp_done_stall", stall_s, 1);

        // flush while full, with rd=9 offered
        bs.out_ready = 1'b0;
        drive_s(1'b1, '{op: 5'h04, f3: 3'd0, rd: 5'd2});
        tick();
        drive_s(1'b1, '{op: 5'h05, f3: 3'd0, rd: 5'd3});
        tick();
        chk("fl_pre_occ", occ_s, 2);
        flush_s = 1'b1;
        drive_s(1'b1, '{op: 5'h09, f3: 3'd3, rd: 5'd9});
        tick();
        chk("fl_occ", occ_s, 0);
        chk("fl_valid", bs.out_valid, 0);
        chk("fl_hz_main", hzm_s, 0);
        chk("fl_hz_skid", hzk_s, 0);
        chk("fl_in_ready", bs.in_ready, 1);
        chk("fl_stall_kept", stall_s, 3);
        // flush from empty with an accepted push: the push is dropped
        tick();
        chk("fl_push_drop_occ", occ_s, 0);
        chk("fl_push_drop_valid", bs.out_valid, 0);
        flush_s = 1'b0;
        drive_s(1'b0, idle);
        tick();
        chk("fl_no_rd9", bs.out_rd, 0);
        chk("fl_no_valid", bs.out_valid, 0);

        // reset mid-operation
        drive_s(1'b1, '{op: 5'h04, f3: 3'd0, rd: 5'd4});
        tick();
        chk("mid_occ", occ_s, 1);
        drive_s(1'b0, idle);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_occ", occ_s, 0);
        chk("mid_rst_valid", bs.out_valid, 0);
        chk("mid_rst_stall", stall_s, 0);

        // stall counter saturation
        drive_s(1'b1, '{op: 5'h06, f3: 3'd0, rd: 5'd6});
        tick();
        drive_s(1'b0, idle);
        chk("sat_start", stall_s, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk($sformatf("sat_%0d", i), stall_s, (i > 7) ? 7 : i);
        end
        bs.out_ready = 1'b1;
        tick();
        chk("sat_pop_occ", occ_s, 0);
        chk("sat_hold", stall_s, 7);

        // no-skid instance: combinational in_ready
        drive_n(1'b1, '{op: 5'h13, f3: 3'd0, rd: 5'd5});
        #1;
        chk("ns_rdy_empty", bn.in_ready, 1);
        tick();
        chk("ns_occ1", occ_n, 1);
        chk("ns_rdy_blocked", bn.in_ready, 0);
        drive_n(1'b1, '{op: 5'h03, f3: 3'd2, rd: 5'd7});
        tick();
        chk("ns_hold_rd", bn.out_rd, 5);
        chk("ns_hold_occ", occ_n, 1);
        bn.out_ready = 1'b1;
        #1;
        chk("ns_rdy_open", bn.in_ready, 1);
        tick();
        chk("ns_pp_rd", bn.out_rd, 7);
        chk("ns_pp_f3", bn.out_f3, 2);
        chk("ns_pp_occ", occ_n, 1);
        chk("ns_hz_skid", hzk_n, 0);
        chk("ns_hz_main", hzm_n, 7);
        drive_n(1'b0, idle);
        tick();
        chk("ns_drain_occ", occ_n, 0);
        chk("ns_stall", stall_n, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl_stage.md
Name: pipe_ctrl_stage

Overview:
- Parametrised elastic control register for one CPU pipeline stage; successor to the fixed per-stage op/f3/rd latch with a single stall input.
- Carries op/funct3/rd of one instruction between stages using valid/ready handshaking.
- Optional 2-entry skid buffer decouples in_ready from out_ready. Adds flush (bubble insertion), valid-qualified rd taps for hazard/forwarding logic, and a saturating stall-cycle counter for cache-miss profiling.

Parameters:
- OP_W, 5, opcode field width.
- F3_W, 3, funct3 field width.
- RD_W, 5, destination-register index width.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- flush  in  1  discard all held entries (branch mispredict / trap).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_op  in  OP_W  opcode.
- in_f3  in  F3_W  funct3.
- in_rd  in  RD_W  destination register.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head (low = waiting / cache miss).
- out_op  out  OP_W  head opcode, 0 when invalid.
- out_f3  out  F3_W  head funct3, 0 when invalid.
- out_rd  out  RD_W  head rd, 0 when invalid.
- hz_rd_main  out  RD_W  head rd if valid, else 0.
- hz_rd_skid  out  RD_W  skid rd if valid, else 0; tied 0 when SKID=0.
- occ  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Interface: one clock domain on clk; reset rst is synchronous and active-low. Sampled only on the rising clk edge; no asynchronous path.
- Reset (rst=0 at the edge): all entries invalid, all fields 0, occ=0, stall_cnt=0, out_valid=0. in_ready=1 from the first cycle after reset.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Every output except in_ready (SKID=0) is registered.
- Latency: a push into an empty stage appears on out_* in the next cycle. Throughput is 1 beat/cycle under continuous out_ready=1.
- SKID=1 states, occ encoding:
  - EMPTY(0): push -> ONE, main<=in.
  - ONE(1), with in_ready=1:
    - push&pop -> ONE, main<=in.
    - push&!pop -> TWO, skid<=in.
    - !push&pop -> EMPTY, main fields cleared to 0.
    - neither -> hold.
  - TWO(2), with in_ready=0: pop -> ONE, main<=skid, skid fields cleared. No push is possible in TWO.
  - SKID=1 in_ready is registered: equals (next occ < 2).
- SKID=0: in_ready = !out_valid | out_ready (combinational); states EMPTY/ONE only. The SKID=1 ONE-state rules apply except the push&!pop row, which cannot occur.
- Bubble rule: an invalid entry always presents all-zero fields. Downstream decodes op=0 as NOP; rd=0 means no write-back.
- Order is strictly FIFO. The skid entry never bypasses main.
- Flush (rst=1, flush=1):
  - Next cycle: occ=0, all fields 0, out_valid=0.
  - A push in the same cycle is dropped. A pop in the same cycle completes downstream normally; the stage just clears.
  - Flush has priority over push/pop; reset has priority over flush.
  - stall_cnt is unaffected by flush.
- stall_cnt increments by 1 in each cycle with out_valid & !out_ready. It holds at 2^CNT_W-1 and never wraps. Cleared only by reset.
- Reset mid-operation discards any in-flight entries without producing a pop.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2;
  - NOP_OP=0;
  - the control-field struct typedef built from OP_W/F3_W/RD_W.
- Natural sub-module pipe_ctrl_entry: one field register with load, clear and valid bit. Instantiate it twice (main, skid); gate the skid instance by SKID.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, out_*=0, occ=0, stall_cnt=0; in_ready=1 in the cycle after rst=1.
- Streaming: push op=0x13, f3=0, rd=5, then op=0x03, f3=2, rd=7 on consecutive cycles with out_ready=1 -> same values on out_* one cycle later in order; occ stays 1.
- Backpressure (SKID=1): out_ready=0, push rd=5 then rd=7 -> occ=2, in_ready=0, hz_rd_main=5, hz_rd_skid=7. Raise out_ready -> rd=5 then rd=7 pop in order, then occ=0.
- Flush in TWO state while pushing rd=9 -> next cycle occ=0, out_valid=0, hz_rd_*=0; rd=9 never appears.
- Stall counter with CNT_W=3: 10 cycles of out_valid=1, out_ready=0 -> stall_cnt reads 1..7 and then holds 7.
- SKID=0 instance: out_ready=0 with head valid -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> push and pop in the same cycle, occ stays 1.
